// File: rtl/aes_encryption_128.sv
// ---------------------------------------------------------------------------
// aes_encryption_128
//   Iterative AES-128 encryption core (FIPS-197), one round per clock.
//   Free-running: every 11 clocks it samples plain_text/key (round 0), runs
//   rounds 1..10 with on-the-fly key expansion, and registers the ciphertext
//   on the edge where round wraps 10 -> 0. encrypt_text then holds until the
//   next block completes.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   plain_text    plaintext block, bits [127:120] are AES byte 0
//   key           cipher key, same byte order
//   encrypt_text  registered ciphertext of the last completed block
//   round         current round counter, 0..R
// ---------------------------------------------------------------------------
module aes_encryption_128 #(
  parameter int N = 128,
  parameter int R = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         plain_text,
  input  logic [N-1:0]         key,
  output logic [N-1:0]         encrypt_text,
  output logic [$clog2(R)-1:0] round
);

  localparam int RW = $clog2(R);
  localparam logic [RW-1:0] LAST_ROUND = RW'(R);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // ---------------------------------------------------------------------------
  // Round primitives. Byte i of a block lives at bits [127-8i -: 8];
  // column c is the 32-bit word at bits [127-32c -: 32].
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = sub_word(s[127-32*c -: 32]);
    return o;
  endfunction

  // Row r of column c takes the byte from column (c + r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiplication by the fixed polynomial {03}x^3 + {01}x^2 + {01}x + {02}.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [RW-1:0] rnd);
    case (rnd)
      RW'(1):  return 8'h01;
      RW'(2):  return 8'h02;
      RW'(3):  return 8'h04;
      RW'(4):  return 8'h08;
      RW'(5):  return 8'h10;
      RW'(6):  return 8'h20;
      RW'(7):  return 8'h40;
      RW'(8):  return 8'h80;
      RW'(9):  return 8'h1b;
      RW'(10): return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [N-1:0]  state_q, state_d;
  logic [N-1:0]  rk_q, rk_d;
  logic [N-1:0]  encrypt_text_q, encrypt_text_d;
  logic [RW-1:0] round_q, round_d;

  logic [31:0]   w0, w1, w2, w3, key_tmp;
  logic [N-1:0]  round_key;
  logic [N-1:0]  sr_state;

  // Next round key K(round) from the previous one held in rk_q.
  always_comb begin
    {w0, w1, w2, w3} = rk_q;
    key_tmp   = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(round_q), 24'h0};
    round_key[127:96] = w0 ^ key_tmp;
    round_key[95:64]  = w1 ^ round_key[127:96];
    round_key[63:32]  = w2 ^ round_key[95:64];
    round_key[31:0]   = w3 ^ round_key[63:32];
  end

  assign sr_state = shift_rows(sub_bytes(state_q));

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d        = state_q;
    rk_d           = rk_q;
    round_d        = round_q;
    encrypt_text_d = encrypt_text_q;

    if (round_q == '0) begin
      // Load: the only edge on which plain_text/key are observed.
      state_d = plain_text ^ key;
      rk_d    = key;
      round_d = RW'(1);
    end else if (round_q == LAST_ROUND) begin
      // Final round has no MixColumns and lands straight on the output.
      encrypt_text_d = sr_state ^ round_key;
      round_d        = '0;
    end else if (round_q < LAST_ROUND) begin
      state_d = mix_columns(sr_state) ^ round_key;
      rk_d    = round_key;
      round_d = round_q + RW'(1);
    end else begin
      // Unreachable encodings recover to a load.
      round_d = '0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= '0;
      rk_q           <= '0;
      round_q        <= '0;
      encrypt_text_q <= '0;
    end else begin
      state_q        <= state_d;
      rk_q           <= rk_d;
      round_q        <= round_d;
      encrypt_text_q <= encrypt_text_d;
    end
  end

  assign encrypt_text = encrypt_text_q;
  assign round        = round_q;

endmodule

// File: tb/tb_aes_encryption_128.sv
// ---------------------------------------------------------------------------
// tb_aes_encryption_128
//   Self-checking bench for aes_encryption_128. The reference is a byte-array
//   AES-128 model whose S-box is derived from the GF(2^8) inverse and affine
//   map, with a fully pre-expanded key schedule. A cycle-phase model predicts
//   round and encrypt_text after every clock edge.
// ---------------------------------------------------------------------------
module tb_aes_encryption_128;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [127:0] plain_text = '0;
  logic [127:0] key = '0;
  logic [127:0] encrypt_text;
  logic [3:0]   round;

  int n_checks = 0;
  int n_errors = 0;

  aes_encryption_128 #(.N(128), .R(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .plain_text   (plain_text),
    .key          (key),
    .encrypt_text (encrypt_text),
    .round        (round)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference AES-128
  // ---------------------------------------------------------------------------
  logic [7:0] sbox_tab [256];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    if (a != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gf_mul(inv, a);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]], sbox_tab[tmp[31:24]]}
              ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
          s[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Cycle model: phase = clock edges since the last load, mod 11
  // ---------------------------------------------------------------------------
  int           phase = 0;
  logic [127:0] exp_ct = '0;
  logic [127:0] cap_pt = '0;
  logic [127:0] cap_key = '0;

  task automatic tick();
    @(posedge clk);
    if (phase == 0) begin
      cap_pt  = plain_text;
      cap_key = key;
    end
    if (phase == 10) exp_ct = aes_ref(cap_pt, cap_key);
    phase = (phase + 1) % 11;
    @(negedge clk);
    check("round", 128'(round), 128'(phase));
    check("encrypt_text", encrypt_text, exp_ct);
  endtask

  // Called at a falling edge; asserts reset, checks the async clear, holds.
  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    check("reset_round", 128'(round), 128'd0);
    check("reset_ct", encrypt_text, 128'd0);
    phase  = 0;
    exp_ct = '0;
    repeat (cycles) @(negedge clk);
    check("reset_hold_round", 128'(round), 128'd0);
    check("reset_hold_ct", encrypt_text, 128'd0);
    rst_n = 1'b1;
  endtask

  // One full block; inputs are scrambled once the load edge has passed.
  task automatic run_block(input logic [127:0] p, input logic [127:0] k);
    while (phase != 0) tick();
    plain_text = p;
    key        = k;
    tick();
    for (int i = 0; i < 10; i++) begin
      plain_text = {$urandom, $urandom, $urandom, $urandom};
      key        = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));

    @(negedge clk);
    do_reset(3);

    run_block(128'h0123456789abcdeffedcba9876543210, 128'h0f1571c947d9e8590cb7add6af7f6798);
    check("kat_stallings", encrypt_text, 128'hff0b844a0853bf7c6934ab4364148fb9);

    run_block(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("kat_fips_b", encrypt_text, 128'h3925841d02dc09fbdc118597196a0b32);

    run_block(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f);
    check("kat_fips_c1", encrypt_text, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    run_block(128'h0, 128'h0);
    check("kat_zero", encrypt_text, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

    for (int b = 0; b < 20; b++)
      run_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});

    // Abort a block mid-flight at round 5, then a clean block after release.
    while (phase != 0) tick();
    plain_text = 128'h00112233445566778899aabbccddeeff;
    key        = 128'h000102030405060708090a0b0c0d0e0f;
    while (phase != 5) tick();
    do_reset(2);
    run_block(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("kat_after_abort", encrypt_text, 128'h3925841d02dc09fbdc118597196a0b32);

    // Output must hold through the following block until it completes.
    for (int i = 0; i < 10; i++) tick();
    check("hold_before_wrap", encrypt_text, 128'h3925841d02dc09fbdc118597196a0b32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
